// File: rtl/biblioteca_mea.sv
// biblioteca_mea: curve constants, point type and scalar-mult controller states
`ifndef NR_BITI
`define NR_BITI 5
`endif
package biblioteca_mea;
  localparam int P_MOD = 29;
  localparam int A_COEF = 4;
  localparam int B_COEF = 20;
  localparam int CURVE_ORD = 37;
  typedef struct packed {
    logic [`NR_BITI-1:0] x;
    logic [`NR_BITI-1:0] y;
    logic inf;
  } punct;
  typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, FIN} sm_state;
endpackage

// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl: left-to-right double-and-add sequencer driving an external point unit
module ec_scalar_mult_ctrl
  import biblioteca_mea::*;
#(
  parameter int W = `NR_BITI,
  parameter int KB = 16,
  parameter int ORD = CURVE_ORD
) (
  input  logic          CLK100MHZ,
  input  logic          RST,
  input  logic          start,
  input  logic [KB-1:0] k,
  input  logic [W-1:0]  px,
  input  logic [W-1:0]  py,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  rx,
  output logic [W-1:0]  ry,
  output logic          rinf,
  output logic          op_start,
  output logic          op_dbl,
  output logic [W-1:0]  op_ax,
  output logic [W-1:0]  op_ay,
  output logic          op_ainf,
  output logic [W-1:0]  op_bx,
  output logic [W-1:0]  op_by,
  input  logic          op_done,
  input  logic [W-1:0]  op_rx,
  input  logic [W-1:0]  op_ry,
  input  logic          op_rinf
);
  localparam int IW = (KB > 1) ? $clog2(KB) : 1;
  sm_state state, state_n;
  logic [KB-1:0] kr, kr_n;
  logic [IW-1:0] i, i_n;
  logic [W-1:0] bx, by, bx_n, by_n, ox, oy, ox_n, oy_n;
  logic oinf, oinf_n, pend, pend_n, ack;
  punct r, r_n;
  always_comb begin
    state_n = state;
    kr_n = kr;
    i_n = i;
    bx_n = bx;
    by_n = by;
    r_n = r;
    ox_n = ox;
    oy_n = oy;
    oinf_n = oinf;
    pend_n = pend;
    ack = pend && op_done;
    op_start = 1'b0;
    op_dbl = state == DBL;
    op_ax = r.x;
    op_ay = r.y;
    op_ainf = r.inf;
    op_bx = bx;
    op_by = by;
    busy = state != IDLE;
    done = state == FIN;
    rx = done ? r.x : ox;
    ry = done ? r.y : oy;
    rinf = done ? r.inf : oinf;
    unique case (state)
      IDLE: if (start) begin
        kr_n = KB'(k % ORD);
        bx_n = px;
        by_n = py;
        i_n = IW'(KB - 1);
        state_n = SCAN;
      end
      SCAN: if (kr == '0) begin
        r_n.inf = 1'b1;
        state_n = FIN;
      end else if (kr[i]) begin
        r_n = '{x: bx, y: by, inf: 1'b0};
        i_n = (i == '0) ? i : i - 1'b1;
        state_n = (i == '0) ? FIN : DBL;
      end else begin
        i_n = i - 1'b1;
      end
      DBL, ADD: begin
        op_start = !pend;
        pend_n = 1'b1;
        if (ack) begin
          r_n = '{x: op_rx, y: op_ry, inf: op_rinf};
          pend_n = 1'b0;
          if (state == DBL && kr[i]) state_n = ADD;
          else if (i == '0) state_n = FIN;
          else begin
            i_n = i - 1'b1;
            state_n = DBL;
          end
        end
      end
      FIN: begin
        ox_n = r.x;
        oy_n = r.y;
        oinf_n = r.inf;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state <= IDLE;
      kr <= '0;
      i <= '0;
      bx <= '0;
      by <= '0;
      r <= '{x: '0, y: '0, inf: 1'b1};
      ox <= '0;
      oy <= '0;
      oinf <= 1'b1;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      kr <= kr_n;
      i <= i_n;
      bx <= bx_n;
      by <= by_n;
      r <= r_n;
      ox <= ox_n;
      oy <= oy_n;
      oinf <= oinf_n;
      pend <= pend_n;
    end
  end
endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// tb_ec_scalar_mult_ctrl: table and random checks of the scalar-mult controller with a mock point unit mod 29
module tb_ec_scalar_mult_ctrl;
    localparam int W = 5;
    localparam int KB = 16;
    logic CLK100MHZ = 1'b0;
    logic RST = 1'b1, start = 1'b0;
    logic [KB-1:0] k = '0;
    logic [W-1:0] px = '0, py = '0, rx, ry, op_ax, op_ay, op_bx, op_by;
    logic [W-1:0] op_rx = '0, op_ry = '0;
    logic busy, done, rinf, op_start, op_dbl, op_ainf;
    logic op_done = 1'b0, op_rinf = 1'b0;
    int tests = 0, fails = 0;

    typedef struct {int x; int y; bit inf;} pt;
    typedef struct {int kv; int erx; int ery; bit einf; int eops; int elat;} vec_t;

    always #5 CLK100MHZ = ~CLK100MHZ;

    ec_scalar_mult_ctrl dut (
        .CLK100MHZ(CLK100MHZ), .RST(RST), .start(start), .k(k), .px(px), .py(py),
        .busy(busy), .done(done), .rx(rx), .ry(ry), .rinf(rinf),
        .op_start(op_start), .op_dbl(op_dbl), .op_ax(op_ax), .op_ay(op_ay), .op_ainf(op_ainf),
        .op_bx(op_bx), .op_by(op_by), .op_done(op_done), .op_rx(op_rx), .op_ry(op_ry), .op_rinf(op_rinf)
    );

    function automatic int md(int a);
        return ((a % 29) + 29) % 29;
    endfunction
    function automatic int inv(int a);
        int r = 1;
        for (int j = 0; j < 27; j++) r = md(r * a);
        return r;
    endfunction
    function automatic pt pinf();
        pt r;
        r.x = 0; r.y = 0; r.inf = 1;
        return r;
    endfunction
    function automatic pt pdbl(pt a);
        pt r;
        int l;
        if (a.inf || a.y == 0) return pinf();
        l = md((3 * a.x * a.x + 4) * inv(md(2 * a.y)));
        r.x = md(l * l - 2 * a.x);
        r.y = md(l * (a.x - r.x) - a.y);
        r.inf = 0;
        return r;
    endfunction
    function automatic pt padd(pt a, pt b);
        pt r;
        int l;
        if (a.inf) return b;
        if (b.inf) return a;
        if (a.x == b.x) return (md(a.y + b.y) == 0) ? pinf() : pdbl(a);
        l = md((b.y - a.y) * inv(md(b.x - a.x)));
        r.x = md(l * l - a.x - b.x);
        r.y = md(l * (a.x - r.x) - a.y);
        r.inf = 0;
        return r;
    endfunction
    // reference: k*P as (k mod 37) repeated additions
    function automatic pt smul(int kv, pt p);
        pt r = pinf();
        repeat (kv % 37) r = padd(r, p);
        return r;
    endfunction
    function automatic int nops_of(int kv);
        int kr = kv % 37, bl = 0, pc = 0;
        for (int j = 0; j < KB; j++) if ((kr >> j) & 1) begin bl = j + 1; pc++; end
        return (kr == 0) ? 0 : (bl - 1) + (pc - 1);
    endfunction

    // mock point unit: answers 3 cycles after op_start, never reset
    int mcnt = 0;
    pt ma, mb, mres;
    bit mdbl;
    always @(posedge CLK100MHZ) begin
        op_done <= 1'b0;
        if (op_start) begin
            ma <= '{x: int'(op_ax), y: int'(op_ay), inf: op_ainf};
            mb <= '{x: int'(op_bx), y: int'(op_by), inf: 1'b0};
            mdbl <= op_dbl;
            mcnt <= 2;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mres = mdbl ? pdbl(ma) : padd(ma, mb);
                op_rx <= W'(mres.x);
                op_ry <= W'(mres.y);
                op_rinf <= mres.inf;
                op_done <= 1'b1;
            end
        end
    end

    int nops = 0, ndone = 0;
    bit dq[$];
    always @(negedge CLK100MHZ) begin
        if (op_start) begin nops++; dq.push_back(op_dbl); end
        if (done) ndone++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // one job: start, optional stray start at cycle poke, wait for done (bounded)
    task automatic run(input int kv, input pt p, input int poke,
                       output int lat, output int ops, output int nd, output pt got);
        int n0, d0;
        @(negedge CLK100MHZ);
        n0 = nops; d0 = ndone;
        k = KB'(kv); px = W'(p.x); py = W'(p.y); start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 2000) begin
            start = (lat == poke);
            if (lat == poke) k = 16'd1;
            @(negedge CLK100MHZ);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", int'(done), 1);
        got.x = int'(rx); got.y = int'(ry); got.inf = rinf;
        repeat (2) @(negedge CLK100MHZ);
        ops = nops - n0;
        nd = ndone - d0;
    endtask

    initial begin
        vec_t tab[$];
        pt base, p, e, got;
        int lat, ops, nd, n0, d0, c;
        base.x = 1; base.y = 5; base.inf = 0;
        e = smul(5, base);
        tab.push_back('{kv: 0, erx: 0, ery: 0, einf: 1, eops: 0, elat: 2});
        tab.push_back('{kv: 1, erx: 1, ery: 5, einf: 0, eops: 0, elat: 17});
        tab.push_back('{kv: 2, erx: 4, ery: 19, einf: 0, eops: 1, elat: -1});
        tab.push_back('{kv: 37, erx: 0, ery: 0, einf: 1, eops: 0, elat: 2});
        tab.push_back('{kv: 38, erx: 1, ery: 5, einf: 0, eops: 0, elat: 17});
        tab.push_back('{kv: 36, erx: 1, ery: 24, einf: 0, eops: 6, elat: -1});
        tab.push_back('{kv: 5, erx: e.x, ery: e.y, einf: 0, eops: 3, elat: -1});
        e = smul(65535, base);
        tab.push_back('{kv: 65535, erx: e.x, ery: e.y, einf: 0, eops: 3, elat: -1});

        // reset, with start asserted to show reset wins
        start = 1'b1; k = 16'd5; px = 5'd1; py = 5'd5;
        repeat (3) @(negedge CLK100MHZ);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rinf", int'(rinf), 1);
        chk("rst_rx", int'(rx), 0);
        chk("rst_op_start", int'(op_start), 0);
        start = 1'b0;
        RST = 1'b0;
        @(negedge CLK100MHZ);
        chk("idle_busy", int'(busy), 0);

        foreach (tab[t]) begin
            run(tab[t].kv, base, 0, lat, ops, nd, got);
            chk($sformatf("t%0d_rinf", tab[t].kv), int'(got.inf), int'(tab[t].einf));
            if (!tab[t].einf) begin
                chk($sformatf("t%0d_rx", tab[t].kv), got.x, tab[t].erx);
                chk($sformatf("t%0d_ry", tab[t].kv), got.y, tab[t].ery);
                chk($sformatf("t%0d_rx_hold", tab[t].kv), int'(rx), tab[t].erx);
            end
            chk($sformatf("t%0d_ops", tab[t].kv), ops, tab[t].eops);
            chk($sformatf("t%0d_ndone", tab[t].kv), nd, 1);
            if (tab[t].elat >= 0) chk($sformatf("t%0d_latency", tab[t].kv), lat, tab[t].elat);
        end

        // k=5 with a stray start mid-job: op order DBL, DBL, ADD
        n0 = dq.size();
        e = smul(5, base);
        run(5, base, 4, lat, ops, nd, got);
        chk("k5_ops", ops, 3);
        chk("k5_rx", got.x, e.x);
        chk("k5_ry", got.y, e.y);
        chk("k5_ndone", nd, 1);
        if (dq.size() >= n0 + 3) chk("k5_dbl_seq", {29'd0, dq[n0], dq[n0+1], dq[n0+2]}, 3'b110);
        else chk("k5_dbl_seq_len", dq.size() - n0, 3);

        // reset during ADD: job dropped, stale op_done ignored
        @(negedge CLK100MHZ);
        k = 16'd5; px = 5'd1; py = 5'd5; start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        c = 0;
        while (!(op_start && !op_dbl) && c < 500) begin @(negedge CLK100MHZ); c++; end
        chk("reach_add", int'(c < 500), 1);
        RST = 1'b1;
        @(negedge CLK100MHZ);
        RST = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rinf", int'(rinf), 1);
        chk("mid_rst_rx", int'(rx), 0);
        d0 = ndone; n0 = nops;
        repeat (8) @(negedge CLK100MHZ);
        chk("mid_rst_no_done", ndone - d0, 0);
        chk("mid_rst_no_ops", nops - n0, 0);
        chk("mid_rst_idle", int'(busy), 0);

        // randomized jobs against the reference model
        for (int n = 0; n < 20; n++) begin
            int kv, m;
            kv = int'($urandom_range(0, 65535));
            m = int'($urandom_range(1, 36));
            p = smul(m, base);
            e = smul(kv, p);
            run(kv, p, 0, lat, ops, nd, got);
            chk($sformatf("r%0d_rinf k=%0d", n, kv), int'(got.inf), int'(e.inf));
            if (!e.inf) begin
                chk($sformatf("r%0d_rx k=%0d", n, kv), got.x, e.x);
                chk($sformatf("r%0d_ry k=%0d", n, kv), got.y, e.y);
            end
            chk($sformatf("r%0d_ops k=%0d", n, kv), ops, nops_of(kv));
            chk($sformatf("r%0d_ndone", n), nd, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ec_scalar_mult_ctrl.md
EC_SCALAR_MULT_CTRL -- requirements
Module: ec_scalar_mult_ctrl

Interface
- REQ-001 SHALL have parameters: W, default `nr_biti, coordinate width; KB, default 16, scalar width; ORD, default 37, curve group order.
- REQ-002 SHALL have port CLK100MHZ, input, 1, the single clock; all logic is on its rising edge.
- REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
- REQ-004 SHALL have port start, input, 1, request a new scalar multiplication.
- REQ-005 SHALL have port k, input, KB, scalar, sampled on the accepted start.
- REQ-006 SHALL have ports px and py, input, W each, base point (punct), sampled on the accepted start.
- REQ-007 SHALL have port busy, output, 1, high while a job is in progress.
- REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
- REQ-009 SHALL have ports rx and ry, output, W each, result point coordinates, held until the next accepted start.
- REQ-010 SHALL have port rinf, output, 1, result is the point at infinity.
- REQ-011 SHALL have port op_start, output, 1, one-cycle pulse requesting a point operation.
- REQ-012 SHALL have port op_dbl, output, 1, 1 = double, 0 = add.
- REQ-013 SHALL have ports op_ax, op_ay and op_ainf, output, W/W/1, operand A (the accumulator R).
- REQ-014 SHALL have ports op_bx and op_by, output, W each, operand B (the latched base point).
- REQ-015 SHALL have port op_done, input, 1, one-cycle pulse from the point unit.
- REQ-016 SHALL have ports op_rx, op_ry and op_rinf, input, W/W/1, point-unit result, valid only with op_done.

Function
- REQ-017 SHALL implement left-to-right double-and-add with states IDLE, SCAN, DBL, ADD, FIN.
- REQ-018 SHALL accept start only in IDLE; in the same edge it SHALL latch kr = k mod ORD, px and py, set i = KB-1, and enter SCAN.
- REQ-019 SHALL ignore start whenever it is not in IDLE.
- REQ-020 SHALL, if kr == 0 in SCAN, go to FIN with R = infinity.
- REQ-021 SHALL otherwise test kr[i] in SCAN, one bit per cycle, decrementing i while the bit is 0.
- REQ-022 SHALL, on the first 1 bit in SCAN, set R = P with inf = 0; it SHALL then go to FIN if i == 0, else decrement i and go to DBL.
- REQ-023 SHALL pulse op_start on the first cycle of DBL and ADD, with op_dbl = 1 in DBL and 0 in ADD.
- REQ-024 SHALL hold the op_* operands stable from op_start until op_done.
- REQ-025 SHALL, on op_done in DBL, latch R from op_r*; it SHALL then go to ADD if kr[i] == 1, else to FIN if i == 0, else decrement i and stay in DBL (new op_start pulse).
- REQ-026 SHALL, on op_done in ADD, latch R; it SHALL then go to FIN if i == 0, else decrement i and go to DBL.
- REQ-027 SHALL ignore op_done arriving in IDLE, SCAN or FIN, and any op_done in DBL or ADD before op_start has issued.
- REQ-028 SHALL, in FIN (one cycle), drive rx/ry/rinf from R, pulse done and return to IDLE.
- REQ-029 SHALL drive busy high from the cycle after the accepted start through the FIN cycle inclusive.
- REQ-030 SHALL treat coordinates as unsigned values already reduced mod p; the controller performs no field arithmetic.

Reset
- REQ-031 SHALL, with RST high on a clock edge, enter IDLE and clear busy, done, op_start, op_dbl, rx, ry, i and kr; it SHALL set rinf = 1.
- REQ-032 SHALL give RST priority over start and op_done in the same cycle.
- REQ-033 SHALL, when reset mid-job, abandon the job with no done pulse and ignore any later op_done.

Structure
- REQ-034 SHALL take the punct struct, `nr_biti, and curve constants p = 29, a = 4, b = 20 and ORD = 37 from biblioteca_mea.
- REQ-035 SHALL place the state enum in biblioteca_mea.
- REQ-036 SHALL contain no sub-module; point arithmetic lives in a separate ec_point_unit wired at top level.

Verification (mock point unit with op_done 3 cycles after op_start, computing real arithmetic mod 29)
- REQ-037 SHALL cover: k=0, P=(1,5) -> done once, rinf=1, op_start never pulsed.
- REQ-038 SHALL cover: k=1, P=(1,5) -> rx=1, ry=5, rinf=0, zero ops, done 17 cycles after start.
- REQ-039 SHALL cover: k=2 -> one DBL op -> rx=4, ry=19; k=37 -> rinf=1; k=38 -> (1,5).
- REQ-040 SHALL cover: k=5 -> op sequence DBL, DBL, ADD (op_dbl 1,1,0), exactly 3 op_start pulses, and start pulsed mid-job is ignored.
- REQ-041 SHALL cover: RST asserted during ADD -> next cycle busy=0, rinf=1, and no done when the stale op_done arrives.
